// File: rtl/lock_cmd_arbiter.sv
// lock_cmd_arbiter
// Round-robin merge of per-accelerator lock/unlock command streams into a
// single registered AXI-Stream. Each output beat carries the source
// accelerator index in out_TID. The output register is reloaded in the same
// cycle it drains, so back-to-back beats flow without bubbles.
//
// Build option: define LOCK_ARB_FILTER_EN to discard granted words whose
// command type is neither lock nor unlock. A discarded word is still
// handshaken and still advances the round-robin pointer. drop_pulse goes
// high for one cycle after the discarded handshake. Without the macro every
// word is forwarded and drop_pulse is tied low.
module lock_cmd_arbiter #(
   parameter  int MAX_ACCS = 16,
   localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [64*MAX_ACCS-1:0] in_TDATA,
   input  logic [MAX_ACCS-1:0]    in_TVALID,
   output logic [MAX_ACCS-1:0]    in_TREADY,
   output logic [63:0]            out_TDATA,
   output logic                   out_TVALID,
   input  logic                   out_TREADY,
   output logic [ACC_BITS-1:0]    out_TID,
   output logic                   drop_pulse
);

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [ACC_BITS-1:0] last_grant_reg, last_grant_next;
   logic [63:0]         tdata_reg, tdata_next;
   logic [ACC_BITS-1:0] tid_reg, tid_next;

   // The input bus viewed as one 64-bit word per accelerator
   logic [63:0]         acc_word [MAX_ACCS];

   // Requesters strictly above the last grant have priority this round
   logic [MAX_ACCS-1:0] above_mask;
   logic [MAX_ACCS-1:0] req_hi;
   logic [ACC_BITS-1:0] hi_idx;
   logic                hi_any;
   logic [ACC_BITS-1:0] lo_idx;
   logic [ACC_BITS-1:0] winner;
   logic [63:0]         win_data;

   logic                any_valid;
   logic                can_load;
   logic                grant;
   logic                cmd_ok;
   logic                load;

   genvar gi;

   generate
      for (gi = 0; gi < MAX_ACCS; gi++) begin : g_acc
         assign acc_word[gi]   = in_TDATA[64*gi +: 64];
         assign above_mask[gi] = (ACC_BITS'(gi) > last_grant_reg);
         assign in_TREADY[gi]  = grant & (winner == ACC_BITS'(gi));
      end
   endgenerate

   assign req_hi = in_TVALID & above_mask;

   // Two lowest-index-first scans: one over requesters above last_grant,
   // one over all requesters (used when the scan has to wrap to 0)
   always_comb begin
      hi_idx = '0;
      hi_any = 1'b0;
      lo_idx = '0;
      for (int i = MAX_ACCS - 1; i >= 0; i--) begin
         if (req_hi[i]) begin
            hi_idx = ACC_BITS'(i);
            hi_any = 1'b1;
         end
         if (in_TVALID[i]) begin
            lo_idx = ACC_BITS'(i);
         end
      end
   end

   assign winner    = hi_any ? hi_idx : lo_idx;
   assign win_data  = acc_word[winner];
   assign any_valid = |in_TVALID;

   // The output register can accept a word when empty or when draining now.
   // Nothing is accepted while reset is held.
   assign can_load = (state_reg == IDLE) | ((state_reg == FULL) & out_TREADY);
   assign grant    = rstn & can_load & any_valid;

`ifdef LOCK_ARB_FILTER_EN
   localparam int CMD_TYPE_H = 7;
   localparam int CMD_TYPE_L = 0;
   localparam logic [CMD_TYPE_H-CMD_TYPE_L:0] CMD_LOCK_CODE   = 8'hAB;
   localparam logic [CMD_TYPE_H-CMD_TYPE_L:0] CMD_UNLOCK_CODE = 8'hCD;

   logic drop_reg;

   assign cmd_ok = (win_data[CMD_TYPE_H:CMD_TYPE_L] == CMD_LOCK_CODE) ||
                   (win_data[CMD_TYPE_H:CMD_TYPE_L] == CMD_UNLOCK_CODE);

   // Flag a handshaken-but-discarded word for exactly one cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         drop_reg <= 1'b0;
      end else begin
         drop_reg <= grant & ~cmd_ok;
      end
   end

   assign drop_pulse = drop_reg;
`else
   assign cmd_ok     = 1'b1;
   assign drop_pulse = 1'b0;
`endif

   assign load = grant & cmd_ok;

   // Next-state logic: load the winner, or drain to IDLE when nothing is loaded
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      tdata_next      = tdata_reg;
      tid_next        = tid_reg;

      if (grant) begin
         last_grant_next = winner;
      end

      if (load) begin
         state_next = FULL;
         tdata_next = win_data;
         tid_next   = winner;
      end else if ((state_reg == FULL) && out_TREADY) begin
         state_next = IDLE;
      end
   end

   // State and output register; reset points last_grant at the top index so
   // acc 0 wins the first arbitration
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         last_grant_reg <= ACC_BITS'(MAX_ACCS - 1);
         tdata_reg      <= '0;
         tid_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         tdata_reg      <= tdata_next;
         tid_reg        <= tid_next;
      end
   end

   assign out_TVALID = (state_reg == FULL);
   assign out_TDATA  = tdata_reg;
   assign out_TID    = tid_reg;

endmodule

// File: tb/tb_lock_cmd_arbiter.sv
// Testbench for lock_cmd_arbiter: directed scenarios plus randomized
// traffic, all checked against a behavioural round-robin model.
module tb_lock_cmd_arbiter;

   localparam int MAX_ACCS = 16;
   localparam int ACC_BITS = 4;
   localparam logic [7:0] LOCK_CODE   = 8'hAB;
   localparam logic [7:0] UNLOCK_CODE = 8'hCD;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [64*MAX_ACCS-1:0] in_TDATA;
   logic [MAX_ACCS-1:0]    in_TVALID;
   logic [MAX_ACCS-1:0]    in_TREADY;
   logic [63:0]            out_TDATA;
   logic                   out_TVALID;
   logic                   out_TREADY;
   logic [ACC_BITS-1:0]    out_TID;
   logic                   drop_pulse;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          m_last  = MAX_ACCS - 1;
   bit          m_valid = 1'b0;
   logic [63:0] m_data  = '0;
   int          m_tid   = 0;
   bit          m_drop  = 1'b0;

   logic [MAX_ACCS-1:0] last_rdy;
   int                  granted;

   lock_cmd_arbiter #(.MAX_ACCS(MAX_ACCS)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_TDATA   (in_TDATA),
      .in_TVALID  (in_TVALID),
      .in_TREADY  (in_TREADY),
      .out_TDATA  (out_TDATA),
      .out_TVALID (out_TVALID),
      .out_TREADY (out_TREADY),
      .out_TID    (out_TID),
      .drop_pulse (drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // First requester found scanning upward from last grant + 1, wrapping
   function automatic int m_winner(input logic [MAX_ACCS-1:0] v);
      int idx;
      for (int k = 1; k <= MAX_ACCS; k++) begin
         idx = (m_last + k) % MAX_ACCS;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit m_cmd_ok(input logic [63:0] w);
`ifdef LOCK_ARB_FILTER_EN
      return (w[7:0] == LOCK_CODE) || (w[7:0] == UNLOCK_CODE);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [63:0] rand_word();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(2))
         0:       w[7:0] = LOCK_CODE;
         1:       w[7:0] = UNLOCK_CODE;
         default: w[7:0] = 8'($urandom_range(255));
      endcase
      return w;
   endfunction

   // One clock: check registered outputs and ready at negedge, advance model at posedge
   task automatic cycle(output int g);
      int          w;
      bit          can;
      logic [MAX_ACCS-1:0] exp_rdy;
      logic [63:0] wd;
      @(negedge clk);
      check_val("out_TVALID", out_TVALID, m_valid);
      check_val("out_TDATA", out_TDATA, m_data);
      check_val("out_TID", out_TID, m_tid);
      check_val("drop_pulse", drop_pulse, m_drop);
      can     = rstn && (!m_valid || out_TREADY);
      w       = m_winner(in_TVALID);
      exp_rdy = '0;
      g       = -1;
      if (can && w >= 0) begin
         exp_rdy[w] = 1'b1;
         g          = w;
      end
      last_rdy = in_TREADY;
      check_val("in_TREADY", in_TREADY, exp_rdy);
      @(posedge clk);
      if (!rstn) begin
         m_last  = MAX_ACCS - 1;
         m_valid = 1'b0;
         m_data  = '0;
         m_tid   = 0;
         m_drop  = 1'b0;
      end else begin
         m_drop = 1'b0;
         if (g >= 0) begin
            m_last = g;
            wd     = in_TDATA[64*g +: 64];
            if (m_cmd_ok(wd)) begin
               m_valid = 1'b1;
               m_data  = wd;
               m_tid   = g;
            end else begin
               m_drop = 1'b1;
               if (out_TREADY) m_valid = 1'b0;
            end
         end else if (out_TREADY) begin
            m_valid = 1'b0;
         end
      end
      $display("cyc t=%0t rstn=%0b vld=%h rdy=%h grant=%0d out_v=%0b tid=%0d data=%h",
               $time, rstn, in_TVALID, last_rdy, g, m_valid, m_tid, m_data);
      #1;
   endtask

   initial begin
      rstn       = 1'b0;
      in_TDATA   = '0;
      in_TVALID  = '0;
      out_TREADY = 1'b0;
      cycle(granted);
      cycle(granted);
      check_val("rst_out_TVALID", out_TVALID, 0);
      check_val("rst_out_TDATA", out_TDATA, 0);
      check_val("rst_out_TID", out_TID, 0);
      check_val("rst_in_TREADY", in_TREADY, 0);
      check_val("rst_drop", drop_pulse, 0);

      // Acc 3 alone with a lock command
      rstn                 = 1'b1;
      out_TREADY           = 1'b1;
      in_TVALID            = 16'h0008;
      in_TDATA[64*3 +: 64] = 64'h0000_0000_0000_00AB;
      cycle(granted);
      check_val("t1_ready", last_rdy, 16'h0008);
      check_val("t1_valid", out_TVALID, 1);
      check_val("t1_data", out_TDATA, 64'hAB);
      check_val("t1_tid", out_TID, 3);

      // All requesters valid for 32 cycles after a fresh reset
      in_TVALID = '0;
      rstn      = 1'b0;
      cycle(granted);
      rstn = 1'b1;
      for (int i = 0; i < MAX_ACCS; i++) begin
         in_TDATA[64*i +: 64] = (64'(i) << 8) | 64'(LOCK_CODE);
      end
      in_TVALID = '1;
      for (int i = 0; i < 32; i++) begin
         cycle(granted);
         check_val("t2_ready", last_rdy, MAX_ACCS'(1) << (i % MAX_ACCS));
         check_val("t2_valid", out_TVALID, 1);
         check_val("t2_tid", out_TID, i % MAX_ACCS);
      end

      // Back-pressure: accs 2 and 5, output stalled after the first grant
      in_TVALID = '0;
      rstn      = 1'b0;
      cycle(granted);
      rstn      = 1'b1;
      in_TVALID = 16'h0024;
      cycle(granted);
      check_val("t3_first", last_rdy, 16'h0004);
      in_TVALID  = 16'h0020;
      out_TREADY = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(granted);
         check_val("t3_hold_rdy", last_rdy, 0);
         check_val("t3_hold_tid", out_TID, 2);
         check_val("t3_hold_valid", out_TVALID, 1);
      end
      out_TREADY = 1'b1;
      cycle(granted);
      check_val("t3_release", last_rdy, 16'h0020);
      check_val("t3_tid5", out_TID, 5);

      // Wrap after acc 15
      in_TVALID = 16'h8000;
      cycle(granted);
      check_val("t4_serve15", last_rdy, 16'h8000);
      in_TVALID = 16'h8001;
      cycle(granted);
      check_val("t4_wrap0", last_rdy, 16'h0001);
      in_TVALID = 16'h8000;
      cycle(granted);
      check_val("t4_then15", last_rdy, 16'h8000);

      // Reset while holding a beat from acc 7
      in_TVALID = 16'h0080;
      cycle(granted);
      check_val("t5_tid7", out_TID, 7);
      out_TREADY = 1'b0;
      in_TVALID  = 16'h0081;
      rstn       = 1'b0;
      cycle(granted);
      check_val("t5_rst_rdy", last_rdy, 0);
      check_val("t5_rst_valid", out_TVALID, 0);
      rstn       = 1'b1;
      out_TREADY = 1'b1;
      cycle(granted);
      check_val("t5_acc0", last_rdy, 16'h0001);
      in_TVALID = 16'h0080;
      cycle(granted);
      check_val("t5_acc7", last_rdy, 16'h0080);

      // Acc 1: unknown command code followed by an unlock
      in_TVALID            = 16'h0002;
      in_TDATA[64*1 +: 64] = 64'h0000_0000_0000_1211;
      cycle(granted);
      check_val("t6_bad_rdy", last_rdy, 16'h0002);
`ifdef LOCK_ARB_FILTER_EN
      check_val("t6_drop", drop_pulse, 1);
      check_val("t6_drop_valid", out_TVALID, 0);
`else
      check_val("t6_nodrop", drop_pulse, 0);
      check_val("t6_fwd_data", out_TDATA, 64'h1211);
`endif
      in_TDATA[64*1 +: 64] = 64'h0000_0000_0000_34CD;
      cycle(granted);
      check_val("t6_unlock_valid", out_TVALID, 1);
      check_val("t6_unlock_data", out_TDATA, 64'h34CD);
      check_val("t6_unlock_tid", out_TID, 1);
      check_val("t6_drop_clear", drop_pulse, 0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rstn       = ($urandom_range(40) != 0);
         out_TREADY = ($urandom_range(3) != 0);
         in_TVALID  = ($urandom_range(3) == 0) ? '1 : MAX_ACCS'($urandom & $urandom);
         for (int i = 0; i < MAX_ACCS; i++) begin
            in_TDATA[64*i +: 64] = rand_word();
         end
         cycle(granted);
      end
      rstn      = 1'b1;
      in_TVALID = '0;
      cycle(granted);
      cycle(granted);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
